// File: rtl/ip_psram_arbiter.sv
// Two-requester arbiter for one ip_psram channel: latches command pulses per port,
// issues them one at a time (round-robin or A-first) and routes read data back.
module ip_psram_arbiter #(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        rd_a,
  input  logic        wr_a,
  input  logic [21:0] address_a,
  input  logic [7:0]  wdata_a,
  output logic        busy_a,
  output logic [7:0]  rdata_a,
  output logic        rdata_en_a,
  input  logic        rd_b,
  input  logic        wr_b,
  input  logic [21:0] address_b,
  input  logic [7:0]  wdata_b,
  output logic        busy_b,
  output logic [7:0]  rdata_b,
  output logic        rdata_en_b,
  output logic        psram_rd,
  output logic        psram_wr,
  output logic [21:0] psram_address,
  output logic [7:0]  psram_wdata,
  input  logic        psram_busy,
  input  logic [7:0]  psram_rdata,
  input  logic        psram_rdata_en
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_ACK  = 2'd1;
  localparam logic [1:0] S_WAIT_DONE = 2'd2;
  localparam logic [1:0] S_WAIT_READ = 2'd3;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  logic [1:0]  state;
  logic        valid_a, valid_b;
  logic        is_read_a, is_read_b;
  logic [21:0] addr_a_q, addr_b_q;
  logic [7:0]  wdata_a_q, wdata_b_q;
  logic        owner, owner_active, cur_read, read_done, last_grant;

  logic        accept_a, accept_b, grant_any, grant_b;
  logic        sel_read;
  logic [21:0] sel_addr;
  logic [7:0]  sel_wdata;

  assign busy_a    = valid_a | (owner_active & (owner == PORT_A));
  assign busy_b    = valid_b | (owner_active & (owner == PORT_B));
  assign accept_a  = (rd_a | wr_a) & ~busy_a;
  assign accept_b  = (rd_b | wr_b) & ~busy_b;
  assign grant_any = (state == S_IDLE) & ~psram_busy & (valid_a | valid_b);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    grant_b   = 1'b0;
    sel_read  = is_read_a;
    sel_addr  = addr_a_q;
    sel_wdata = wdata_a_q;
    if (valid_b && (!valid_a || (!FIXED_PRIORITY && last_grant == PORT_A))) begin
      grant_b = 1'b1;
    end
    if (grant_b) begin
      sel_read  = is_read_b;
      sel_addr  = addr_b_q;
      sel_wdata = wdata_b_q;
    end
  end

  // Pending command registers; rd wins over wr when both pulse together.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      valid_a   <= 1'b0;
      is_read_a <= 1'b0;
      addr_a_q  <= '0;
      wdata_a_q <= '0;
      valid_b   <= 1'b0;
      is_read_b <= 1'b0;
      addr_b_q  <= '0;
      wdata_b_q <= '0;
    end else begin
      if (accept_a) begin
        valid_a   <= 1'b1;
        is_read_a <= rd_a;
        addr_a_q  <= address_a;
        wdata_a_q <= wdata_a;
      end else if (grant_any && !grant_b) begin
        valid_a <= 1'b0;
      end
      if (accept_b) begin
        valid_b   <= 1'b1;
        is_read_b <= rd_b;
        addr_b_q  <= address_b;
        wdata_b_q <= wdata_b;
      end else if (grant_any && grant_b) begin
        valid_b <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state         <= S_IDLE;
      owner         <= PORT_A;
      owner_active  <= 1'b0;
      cur_read      <= 1'b0;
      read_done     <= 1'b0;
      last_grant    <= PORT_B;
      psram_rd      <= 1'b0;
      psram_wr      <= 1'b0;
      psram_address <= '0;
      psram_wdata   <= '0;
      rdata_a       <= '0;
      rdata_b       <= '0;
      rdata_en_a    <= 1'b0;
      rdata_en_b    <= 1'b0;
    end else begin
      psram_rd   <= 1'b0;
      psram_wr   <= 1'b0;
      rdata_en_a <= 1'b0;
      rdata_en_b <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            owner         <= grant_b;
            owner_active  <= 1'b1;
            last_grant    <= grant_b;
            cur_read      <= sel_read;
            read_done     <= 1'b0;
            psram_address <= sel_addr;
            psram_wdata   <= sel_wdata;
            psram_rd      <= sel_read;
            psram_wr      <= ~sel_read;
            state         <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          state <= cur_read ? S_WAIT_READ : S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (!psram_busy) begin
            owner_active <= 1'b0;
            state        <= S_IDLE;
          end
        end
        S_WAIT_READ: begin
          if (psram_rdata_en && !read_done) begin
            read_done <= 1'b1;
            if (owner == PORT_A) begin
              rdata_a    <= psram_rdata;
              rdata_en_a <= 1'b1;
            end else begin
              rdata_b    <= psram_rdata;
              rdata_en_b <= 1'b1;
            end
          end
          // The data strobe and the busy release may arrive in the same cycle.
          if ((read_done || psram_rdata_en) && !psram_busy) begin
            owner_active <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ip_psram_arbiter.sv
// Scoreboard bench for ip_psram_arbiter: round-robin instance driven by directed
// vectors against a small ip_psram model, plus a fixed-priority instance.
module tb_ip_psram_arbiter;

  typedef struct packed {
    logic        is_read;
    logic [21:0] addr;
    logic [7:0]  wdata;
  } cmd_t;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Round-robin instance signals
  logic        rd_a = 0, wr_a = 0, rd_b = 0, wr_b = 0;
  logic [21:0] address_a = 0, address_b = 0;
  logic [7:0]  wdata_a = 0, wdata_b = 0;
  logic        busy_a, busy_b, rdata_en_a, rdata_en_b;
  logic [7:0]  rdata_a, rdata_b;
  logic        psram_rd, psram_wr, psram_busy, psram_rdata_en;
  logic [21:0] psram_address;
  logic [7:0]  psram_wdata, psram_rdata;

  // Fixed-priority instance signals
  logic        rd_a_f = 0, wr_a_f = 0, rd_b_f = 0, wr_b_f = 0;
  logic [21:0] address_a_f = 22'h0A0000, address_b_f = 22'h0B0000;
  logic [7:0]  wdata_a_f = 8'h0A, wdata_b_f = 8'h0B;
  logic        busy_a_f, busy_b_f, rdata_en_a_f, rdata_en_b_f;
  logic [7:0]  rdata_a_f, rdata_b_f;
  logic        psram_rd_f, psram_wr_f, psram_busy_f, psram_rdata_en_f;
  logic [21:0] psram_address_f;
  logic [7:0]  psram_wdata_f, psram_rdata_f;

  ip_psram_arbiter #(.FIXED_PRIORITY(1'b0)) dut (
    .clk(clk), .n_reset(n_reset),
    .rd_a(rd_a), .wr_a(wr_a), .address_a(address_a), .wdata_a(wdata_a),
    .busy_a(busy_a), .rdata_a(rdata_a), .rdata_en_a(rdata_en_a),
    .rd_b(rd_b), .wr_b(wr_b), .address_b(address_b), .wdata_b(wdata_b),
    .busy_b(busy_b), .rdata_b(rdata_b), .rdata_en_b(rdata_en_b),
    .psram_rd(psram_rd), .psram_wr(psram_wr), .psram_address(psram_address),
    .psram_wdata(psram_wdata), .psram_busy(psram_busy),
    .psram_rdata(psram_rdata), .psram_rdata_en(psram_rdata_en)
  );

  ip_psram_arbiter #(.FIXED_PRIORITY(1'b1)) dut_fp (
    .clk(clk), .n_reset(n_reset),
    .rd_a(rd_a_f), .wr_a(wr_a_f), .address_a(address_a_f), .wdata_a(wdata_a_f),
    .busy_a(busy_a_f), .rdata_a(rdata_a_f), .rdata_en_a(rdata_en_a_f),
    .rd_b(rd_b_f), .wr_b(wr_b_f), .address_b(address_b_f), .wdata_b(wdata_b_f),
    .busy_b(busy_b_f), .rdata_b(rdata_b_f), .rdata_en_b(rdata_en_b_f),
    .psram_rd(psram_rd_f), .psram_wr(psram_wr_f), .psram_address(psram_address_f),
    .psram_wdata(psram_wdata_f), .psram_busy(psram_busy_f),
    .psram_rdata(psram_rdata_f), .psram_rdata_en(psram_rdata_en_f)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] mem_data(input logic [21:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // ---------------- ip_psram model (round-robin instance) ----------------
  logic        force_busy = 0, stray_en = 0;
  logic        m_active = 0, m_read = 0;
  int          m_issue = 0;
  logic [21:0] m_addr = 0;

  initial begin
    psram_busy = 0; psram_rdata = 0; psram_rdata_en = 0;
    forever begin
      @(posedge clk); #2;
      if (!n_reset) m_active = 0;
      else if (psram_rd || psram_wr) begin
        m_active = 1; m_issue = cyc; m_read = psram_rd; m_addr = psram_address;
      end
      psram_busy = force_busy | (m_active && cyc > m_issue && cyc <= m_issue + (m_read ? 7 : 4));
      psram_rdata_en = stray_en | (m_active && m_read && cyc == m_issue + 8);
      psram_rdata = stray_en ? 8'hEE : (psram_rdata_en ? mem_data(m_addr) : 8'h00);
      if (m_active && cyc >= m_issue + 8) m_active = 0;
    end
  end

  // ---------------- ip_psram stub (fixed-priority instance) ----------------
  logic f_active = 0;
  int   f_issue = 0;
  initial begin
    psram_busy_f = 0; psram_rdata_f = 0; psram_rdata_en_f = 0;
    forever begin
      @(posedge clk); #2;
      if (!n_reset) f_active = 0;
      else if (psram_rd_f || psram_wr_f) begin f_active = 1; f_issue = cyc; end
      psram_busy_f = f_active && cyc > f_issue && cyc <= f_issue + 3;
      if (f_active && cyc > f_issue + 3) f_active = 0;
    end
  end

  // ---------------- scoreboard / monitors ----------------
  cmd_t       exp_cmd[$];
  logic [7:0] exp_rd_a[$], exp_rd_b[$];
  int cmd_cnt = 0, rden_a_cnt = 0, rden_b_cnt = 0;
  int last_cmd_cyc = 0, last_rden_b_cyc = 0;

  always @(negedge clk) begin
    if (n_reset) begin
      if (psram_rd || psram_wr) begin
        cmd_cnt++;
        last_cmd_cyc = cyc;
        if (exp_cmd.size() == 0) begin
          check("unexpected_cmd", 64'({psram_rd, psram_wr, psram_address}), 64'(0));
        end else begin
          cmd_t e;
          e = exp_cmd.pop_front();
          check("cmd_type", 64'({psram_rd, psram_wr}), 64'({e.is_read, ~e.is_read}));
          check("cmd_addr", 64'(psram_address), 64'(e.addr));
          if (!e.is_read) check("cmd_wdata", 64'(psram_wdata), 64'(e.wdata));
        end
      end
      if (rdata_en_a) begin
        rden_a_cnt++;
        if (exp_rd_a.size() == 0) check("unexpected_rdata_en_a", 64'(rdata_a), 64'h100);
        else check("rdata_a", 64'(rdata_a), 64'(exp_rd_a.pop_front()));
      end
      if (rdata_en_b) begin
        rden_b_cnt++;
        last_rden_b_cyc = cyc;
        if (exp_rd_b.size() == 0) check("unexpected_rdata_en_b", 64'(rdata_b), 64'h100);
        else check("rdata_b", 64'(rdata_b), 64'(exp_rd_b.pop_front()));
      end
    end
  end

  // Fixed-priority monitor: B may only be granted while A has nothing pending.
  logic a_out = 0;
  int   a_acc = 0, grants_a_f = 0, grants_b_f = 0;
  int   fp_order[$];
  always @(negedge clk) begin
    if (n_reset && psram_wr_f) begin
      if (psram_address_f == 22'h0A0000) begin
        grants_a_f++; a_out = 0; fp_order.push_back(0);
      end else begin
        grants_b_f++; fp_order.push_back(1);
        check("fp_b_while_a_pending", 64'(a_out && (a_acc <= cyc - 2)), 64'(0));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) tick();
  endtask

  task automatic drive(input logic ra, input logic wa, input logic [21:0] aa, input logic [7:0] da,
                       input logic rb, input logic wb, input logic [21:0] ab, input logic [7:0] db);
    rd_a = ra; wr_a = wa; address_a = aa; wdata_a = da;
    rd_b = rb; wr_b = wb; address_b = ab; wdata_b = db;
    tick();
    rd_a = 0; wr_a = 0; rd_b = 0; wr_b = 0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while ((busy_a || busy_b || exp_cmd.size() != 0) && k < 300) begin tick(); k++; end
    if (k >= 300) check(name, 64'({busy_a, busy_b}), 64'(0));
    repeat (3) tick();
  endtask

  task automatic push_cmd(input logic is_rd, input logic [21:0] a, input logic [7:0] d);
    cmd_t c;
    c.is_read = is_rd; c.addr = a; c.wdata = d;
    exp_cmd.push_back(c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0, n0, r0;
    logic [21:0] aa, ab;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", 64'({busy_a, busy_b, rdata_en_a, rdata_en_b, psram_rd, psram_wr}), 64'(0));
    check("rst_addr", 64'(psram_address), 64'(0));
    check("rst_wdata", 64'(psram_wdata), 64'(0));
    check("rst_rdata", 64'({rdata_a, rdata_b}), 64'(0));
    check("rst_fp_ctrl", 64'({busy_a_f, busy_b_f, psram_wr_f, psram_rd_f}), 64'(0));
    n_reset = 1;
    tick();

    // Single write A: psram_wr exactly in cycle 2
    tick(); c0 = cyc; n0 = cmd_cnt;
    push_cmd(1'b0, 22'h012345, 8'hA5);
    check("w1_busy_c0", 64'(busy_a), 64'(0));
    drive(0, 1, 22'h012345, 8'hA5, 0, 0, 0, 0);
    check("w1_busy_c1", 64'(busy_a), 64'(1));
    wait_until(c0 + 6);
    check("w1_busy_c6", 64'(busy_a), 64'(1));
    wait_idle("w1_timeout");
    check("w1_issue_cycle", 64'(last_cmd_cyc - c0), 64'(2));
    check("w1_cmd_count", 64'(cmd_cnt - n0), 64'(1));

    // Single read B at top address: strobe in cycle 11
    tick(); c0 = cyc;
    push_cmd(1'b1, 22'h3FFFFF, 8'h00);
    exp_rd_b.push_back(8'h5A);
    drive(0, 0, 0, 0, 1, 0, 22'h3FFFFF, 8'h00);
    wait_idle("r1_timeout");
    check("r1_rden_cycle", 64'(last_rden_b_cyc - c0), 64'(11));
    check("r1_rdata_hold", 64'(rdata_b), 64'h5A);
    check("r1_no_rden_a", 64'(rden_a_cnt), 64'(0));

    // Round-robin ties, three in a row: A, B, A, B, A, B
    for (int i = 0; i < 3; i++) begin
      tick();
      aa = 22'h010000 + 22'(i * 22'h000111);
      ab = 22'h200000 + 22'(i * 22'h000222);
      push_cmd(1'b1, aa, 8'h00);
      push_cmd(1'b1, ab, 8'h00);
      exp_rd_a.push_back(mem_data(aa));
      exp_rd_b.push_back(mem_data(ab));
      drive(1, 0, aa, 8'h00, 1, 0, ab, 8'h00);
      wait_idle("tie_timeout");
    end
    check("tie_rden_a_count", 64'(rden_a_cnt), 64'(3));
    check("tie_rden_b_count", 64'(rden_b_cnt), 64'(4));

    // Pulse while busy is ignored
    tick(); n0 = cmd_cnt;
    push_cmd(1'b0, 22'h000ABC, 8'h11);
    drive(0, 1, 22'h000ABC, 8'h11, 0, 0, 0, 0);
    drive(0, 1, 22'h3ABCDE, 8'h22, 0, 0, 0, 0);
    wait_idle("ign_timeout");
    check("ign_cmd_count", 64'(cmd_cnt - n0), 64'(1));

    // rd and wr together: one read
    tick(); n0 = cmd_cnt;
    push_cmd(1'b1, 22'h0155AA, 8'h00);
    exp_rd_a.push_back(mem_data(22'h0155AA));
    drive(1, 1, 22'h0155AA, 8'h99, 0, 0, 0, 0);
    wait_idle("rdwr_timeout");
    check("rdwr_cmd_count", 64'(cmd_cnt - n0), 64'(1));

    // Stray psram_rdata_en in IDLE
    r0 = rden_a_cnt + rden_b_cnt;
    tick(); stray_en = 1;
    tick(); stray_en = 0;
    repeat (4) tick();
    check("stray_no_rden", 64'(rden_a_cnt + rden_b_cnt - r0), 64'(0));

    // psram_busy high in IDLE stalls issue; command is held
    force_busy = 1;
    tick(); n0 = cmd_cnt;
    push_cmd(1'b0, 22'h022222, 8'h33);
    drive(0, 0, 0, 0, 0, 1, 22'h022222, 8'h33);
    repeat (10) tick();
    check("stall_no_issue", 64'(cmd_cnt - n0), 64'(0));
    check("stall_busy_b", 64'(busy_b), 64'(1));
    force_busy = 0;
    wait_idle("stall_timeout");
    check("stall_issued", 64'(cmd_cnt - n0), 64'(1));

    // Other port accepted while a command is in flight
    tick(); c0 = cyc;
    push_cmd(1'b1, 22'h0C0C0C, 8'h00);
    exp_rd_a.push_back(mem_data(22'h0C0C0C));
    drive(1, 0, 22'h0C0C0C, 8'h00, 0, 0, 0, 0);
    wait_until(c0 + 4);
    check("flight_busy_b_low", 64'(busy_b), 64'(0));
    push_cmd(1'b0, 22'h0D0D0D, 8'h44);
    drive(0, 0, 0, 0, 0, 1, 22'h0D0D0D, 8'h44);
    check("flight_busy_b_high", 64'(busy_b), 64'(1));
    wait_idle("flight_timeout");

    // Reset in WAIT_READ drops the access
    tick(); c0 = cyc; r0 = rden_a_cnt;
    push_cmd(1'b1, 22'h1F0F0F, 8'h00);
    drive(1, 0, 22'h1F0F0F, 8'h00, 0, 0, 0, 0);
    wait_until(c0 + 5);
    @(negedge clk);
    n_reset = 0;
    #1;
    check("rrst_ctrl", 64'({busy_a, busy_b, rdata_en_a, rdata_en_b, psram_rd, psram_wr}), 64'(0));
    check("rrst_data", 64'({psram_address, psram_wdata, rdata_a, rdata_b}), 64'(0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_reset = 1;
    repeat (15) tick();
    check("rrst_no_strobe", 64'(rden_a_cnt - r0), 64'(0));
    tick(); c0 = cyc;
    push_cmd(1'b0, 22'h000777, 8'h88);
    drive(0, 1, 22'h000777, 8'h88, 0, 0, 0, 0);
    wait_idle("rrst_wr_timeout");
    check("rrst_wr_issue_cycle", 64'(last_cmd_cyc - c0), 64'(2));

    check("sb_cmd_empty", 64'(exp_cmd.size()), 64'(0));
    check("sb_rd_empty", 64'(exp_rd_a.size() + exp_rd_b.size()), 64'(0));

    // Fixed priority: both ports re-request as soon as their busy drops
    for (int i = 0; i < 80; i++) begin
      tick();
      wr_a_f = !busy_a_f;
      wr_b_f = !busy_b_f;
      if (wr_a_f) begin a_out = 1; a_acc = cyc; end
    end
    tick(); wr_a_f = 0; wr_b_f = 0;
    for (int k = 0; k < 100 && (busy_a_f || busy_b_f); k++) tick();
    repeat (3) tick();
    check("fp_a_grants", 64'(grants_a_f > 3), 64'(1));
    check("fp_b_grants", 64'(grants_b_f > 3), 64'(1));

    // After an A grant, a tie must still go to A
    wr_a_f = 1; a_out = 1; a_acc = cyc;
    tick(); wr_a_f = 0;
    for (int k = 0; k < 100 && busy_a_f; k++) tick();
    repeat (3) tick();
    fp_order.delete();
    wr_a_f = 1; wr_b_f = 1; a_out = 1; a_acc = cyc;
    tick(); wr_a_f = 0; wr_b_f = 0;
    for (int k = 0; k < 100 && (busy_a_f || busy_b_f); k++) tick();
    repeat (3) tick();
    check("fp_tie_count", 64'(fp_order.size()), 64'(2));
    if (fp_order.size() > 0) check("fp_tie_first_is_a", 64'(fp_order[0]), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
